crack_job_scheduler: RTL and testbench
======================================

Name: crack_job_scheduler

Overview:
Dynamic work scheduler for a pool of password_cracker workers. It splits the first-character index space (0..CHARSET_SIZE-1) into fixed-size chunks and hands each chunk to whichever worker is idle. It aborts all workers when any of them finds the password, and reports a single found/done result. It replaces static from/to wiring and the AND-of-dones in the top level.

Parameters:
- NUM_WORKERS, 4, number of attached cracker workers (1..8)
- CHARSET_SIZE, 36, number of first-character indices to search
- CHUNK, 4, indices per dispatched range (>=1)
- IDX_W, 6, width of from/to indices
- PW_W, 32, password width (4 chars x 8 bits)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse; begin a job (ignored while busy=1)
- password_to_crack  in  PW_W  target; sampled on accepted start
- wk_password  out  PW_W  latched target, fanned out to all workers
- wk_start  out  NUM_WORKERS  one-cycle launch pulse per worker
- wk_from  out  NUM_WORKERS*IDX_W  per-worker range start (worker i at [i*IDX_W +: IDX_W])
- wk_to  out  NUM_WORKERS*IDX_W  per-worker range end, inclusive
- wk_abort  out  NUM_WORKERS  one-cycle kill pulse per worker
- wk_found  in  NUM_WORKERS  one-cycle pulse: worker matched
- wk_guess  in  NUM_WORKERS*PW_W  worker's matching password; valid with wk_found
- wk_done  in  NUM_WORKERS  one-cycle pulse: worker exhausted its range, no match
- busy  out  1  job in progress
- found  out  1  password recovered (sticky until next accepted start)
- done  out  1  job finished, found or not (sticky until next accepted start)
- cracked_pw  out  PW_W  recovered password, valid when found=1
- found_worker  out  3  index of the worker that matched
- chunks_issued  out  IDX_W  count of ranges dispatched in the current job

Behaviour:
- Reset: all outputs 0, FSM=IDLE, all worker-busy flags 0, next_from=0. Reset mid-job drops the job immediately and issues no wk_abort; the workers' own rst clears them.
- FSM states: IDLE, RUN, ABORT, FINISH.
- IDLE/FINISH + start: latch password, clear found/done/cracked_pw/found_worker/chunks_issued, next_from=0, go to RUN, busy=1 on the next cycle. start during RUN/ABORT is ignored.
- RUN dispatch: at most one dispatch per cycle, to the lowest-index worker that is idle, while next_from < CHARSET_SIZE.
  - Drive wk_start[i]=1 for exactly one cycle with wk_from=next_from and wk_to=min(next_from+CHUNK-1, CHARSET_SIZE-1).
  - next_from += CHUNK; chunks_issued++; set worker i busy.
  - wk_from/wk_to for a worker stay registered until its next dispatch.
- The first dispatch occurs in the first cycle of RUN, i.e. the cycle after start is accepted.
- RUN completion: wk_done[i] clears busy[i]. The worker becomes eligible for dispatch in the following cycle, not the same cycle.
- RUN match:
  - Any wk_found[i] latches cracked_pw=wk_guess[i] and found_worker=i, then goes to ABORT.
  - If several workers assert wk_found in the same cycle, the lowest index wins.
  - No dispatch occurs in a cycle in which any wk_found is asserted.
  - If a worker asserts wk_found and wk_done in the same cycle, found wins.
- ABORT (1 cycle): wk_abort[i]=1 for every worker still busy. Clear all busy flags, set found=1 and done=1, busy=0, then go to FINISH.
- RUN exhaust: when next_from >= CHARSET_SIZE and no worker is busy, set done=1, found=0, busy=0 and go to FINISH.
- Wrap-around: next_from is IDX_W+1 bits wide internally so the increment never wraps. A final partial chunk is clamped by the min() rule.
- Pulses from idle workers (wk_done or wk_found with busy[i]=0) are ignored.

Test Plan:
- Default params, no worker ever asserts found; each worker pulses wk_done 10 cycles after its wk_start -> exactly 9 dispatches with ranges 0-3, 4-7, ..., 32-35; chunks_issued=9; done=1, found=0, busy=0; no wk_abort.
- CHARSET_SIZE=10, CHUNK=4 -> ranges 0-3, 4-7, 8-9 (last chunk clamped); done after the last wk_done.
- Worker 2 pulses wk_found with wk_guess=32'h61626364 while workers 0, 1 and 3 are busy -> one-cycle ABORT; wk_abort=4'b1011; cracked_pw=32'h61626364; found_worker=2; found=done=1; no wk_start from that cycle on.
- wk_found on workers 1 and 3 in the same cycle -> found_worker=1, cracked_pw=wk_guess[1].
- Worker 0 pulses wk_done in cycle t -> its next wk_start is no earlier than t+1; start asserted mid-RUN is ignored (chunks_issued unchanged, next_from unchanged).
- rst asserted mid-RUN -> next cycle all outputs 0, FSM=IDLE; a new start then dispatches from index 0 again.

Source files
------------

// File: rtl/crack_job_scheduler.sv
// crack_job_scheduler: hands out fixed-size first-character ranges to a pool
// of password_cracker workers, aborts the pool on the first match and reports
// one found/done result per job.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle job request (ignored while a job runs)
//   password_to_crack   target, captured when start is accepted
//   wk_password         captured target, shared by all workers
//   wk_start/wk_abort   per-worker one-cycle launch / kill pulses
//   wk_from/wk_to       per-worker inclusive range, worker i at [i*IDX_W +: IDX_W]
//   wk_found/wk_guess   per-worker match pulse and matching password
//   wk_done             per-worker "range exhausted" pulse
//   busy/found/done     job status; found and done stay set until the next job
//   cracked_pw          recovered password, found_worker its worker index
//   chunks_issued       ranges dispatched in the current job
module crack_job_scheduler #(
    parameter int unsigned NUM_WORKERS  = 4,
    parameter int unsigned CHARSET_SIZE = 36,
    parameter int unsigned CHUNK        = 4,
    parameter int unsigned IDX_W        = 6,
    parameter int unsigned PW_W         = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [PW_W-1:0]              password_to_crack,
    output logic [PW_W-1:0]              wk_password,
    output logic [NUM_WORKERS-1:0]       wk_start,
    output logic [NUM_WORKERS*IDX_W-1:0] wk_from,
    output logic [NUM_WORKERS*IDX_W-1:0] wk_to,
    output logic [NUM_WORKERS-1:0]       wk_abort,
    input  logic [NUM_WORKERS-1:0]       wk_found,
    input  logic [NUM_WORKERS*PW_W-1:0]  wk_guess,
    input  logic [NUM_WORKERS-1:0]       wk_done,
    output logic                         busy,
    output logic                         found,
    output logic                         done,
    output logic [PW_W-1:0]              cracked_pw,
    output logic [2:0]                   found_worker,
    output logic [IDX_W-1:0]             chunks_issued
);

    // One extra bit so next_from can step past the last index without wrapping.
    localparam int unsigned NF_W     = IDX_W + 1;
    localparam int unsigned LAST_IDX = CHARSET_SIZE - 1;

    typedef enum logic [1:0] {IDLE, RUN, ABORT, FINISH} state_t;

    state_t                 state;
    logic [NUM_WORKERS-1:0] wbusy;
    logic [NF_W-1:0]        next_from;

    logic [NUM_WORKERS-1:0] found_hit;
    logic [NUM_WORKERS-1:0] done_hit;
    logic [NUM_WORKERS-1:0] disp_mask;
    logic                   found_any;
    logic                   more_work;
    logic [2:0]             found_idx;
    logic [PW_W-1:0]        guess_sel;
    logic [31:0]            range_end;
    logic [IDX_W-1:0]       range_to;

    // Match winner, dispatch target and clamped range end for this cycle.
    always_comb begin
        found_hit = wk_found & wbusy;
        done_hit  = wk_done & wbusy;
        found_any = |found_hit;
        more_work = 32'(next_from) < CHARSET_SIZE;
        found_idx = '0;
        guess_sel = '0;
        disp_mask = '0;

        // Descending scans: the last hit written is the lowest index.
        for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
            if (found_hit[i]) begin
                found_idx = 3'(i);
                guess_sel = wk_guess[i*PW_W +: PW_W];
            end
        end

        // Uses the registered busy flags, so a worker reporting done this
        // cycle is only eligible from the next cycle on.
        if (state == RUN && more_work && !found_any) begin
            for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
                if (!wbusy[i]) begin
                    disp_mask    = '0;
                    disp_mask[i] = 1'b1;
                end
            end
        end

        range_end = 32'(next_from) + CHUNK - 1;
        if (range_end > LAST_IDX) begin
            range_end = LAST_IDX;
        end
        range_to = IDX_W'(range_end);
    end

    // Job FSM with registered worker-side and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wbusy         <= '0;
            next_from     <= '0;
            wk_password   <= '0;
            wk_start      <= '0;
            wk_from       <= '0;
            wk_to         <= '0;
            wk_abort      <= '0;
            busy          <= 1'b0;
            found         <= 1'b0;
            done          <= 1'b0;
            cracked_pw    <= '0;
            found_worker  <= '0;
            chunks_issued <= '0;
        end else begin
            wk_start <= disp_mask;
            wk_abort <= '0;

            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        wk_password   <= password_to_crack;
                        found         <= 1'b0;
                        done          <= 1'b0;
                        cracked_pw    <= '0;
                        found_worker  <= '0;
                        chunks_issued <= '0;
                        next_from     <= '0;
                        busy          <= 1'b1;
                        state         <= RUN;
                    end
                end

                RUN: begin
                    if (found_any) begin
                        cracked_pw   <= guess_sel;
                        found_worker <= found_idx;
                        // Workers that just reported are already idle.
                        wk_abort     <= wbusy & ~(wk_found | wk_done);
                        state        <= ABORT;
                    end else if (!more_work && wbusy == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FINISH;
                    end else begin
                        wbusy <= (wbusy & ~done_hit) | disp_mask;
                        if (|disp_mask) begin
                            next_from     <= next_from + NF_W'(CHUNK);
                            chunks_issued <= chunks_issued + IDX_W'(1);
                        end
                    end
                end

                ABORT: begin
                    wbusy <= '0;
                    found <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= FINISH;
                end

                default: state <= IDLE;
            endcase

            for (int i = 0; i < NUM_WORKERS; i++) begin
                if (disp_mask[i]) begin
                    wk_from[i*IDX_W +: IDX_W] <= IDX_W'(next_from);
                    wk_to[i*IDX_W +: IDX_W]   <= range_to;
                end
            end
        end
    end

endmodule

// File: tb/tb_crack_job_scheduler.sv
// tb_crack_job_scheduler: drives crack_job_scheduler with modelled workers
// (random run lengths, random or directed matches) and checks every cycle
// against a range/worker-pool model; a second instance covers a clamped
// final chunk.
module tb_crack_job_scheduler;

    localparam int NW = 4;
    localparam int CS = 36;
    localparam int CK = 4;
    localparam int IW = 6;
    localparam int PW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             start;
    logic [PW-1:0]    password_to_crack;
    logic [PW-1:0]    wk_password;
    logic [NW-1:0]    wk_start;
    logic [NW*IW-1:0] wk_from;
    logic [NW*IW-1:0] wk_to;
    logic [NW-1:0]    wk_abort;
    logic [NW-1:0]    wk_found;
    logic [NW*PW-1:0] wk_guess;
    logic [NW-1:0]    wk_done;
    logic             busy;
    logic             found;
    logic             done;
    logic [PW-1:0]    cracked_pw;
    logic [2:0]       found_worker;
    logic [IW-1:0]    chunks_issued;

    logic             b_start;
    logic [PW-1:0]    b_pw;
    logic [PW-1:0]    b_wk_password;
    logic [NW-1:0]    b_wk_start;
    logic [NW*IW-1:0] b_wk_from;
    logic [NW*IW-1:0] b_wk_to;
    logic [NW-1:0]    b_wk_abort;
    logic [NW-1:0]    b_wk_found;
    logic [NW*PW-1:0] b_wk_guess;
    logic [NW-1:0]    b_wk_done;
    logic             b_busy;
    logic             b_found;
    logic             b_done;
    logic [PW-1:0]    b_cracked_pw;
    logic [2:0]       b_found_worker;
    logic [IW-1:0]    b_chunks;

    crack_job_scheduler #(
        .NUM_WORKERS(NW), .CHARSET_SIZE(CS), .CHUNK(CK), .IDX_W(IW), .PW_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .password_to_crack(password_to_crack),
        .wk_password(wk_password), .wk_start(wk_start), .wk_from(wk_from),
        .wk_to(wk_to), .wk_abort(wk_abort), .wk_found(wk_found),
        .wk_guess(wk_guess), .wk_done(wk_done), .busy(busy), .found(found),
        .done(done), .cracked_pw(cracked_pw), .found_worker(found_worker),
        .chunks_issued(chunks_issued)
    );

    crack_job_scheduler #(
        .NUM_WORKERS(NW), .CHARSET_SIZE(10), .CHUNK(4), .IDX_W(IW), .PW_W(PW)
    ) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .password_to_crack(b_pw),
        .wk_password(b_wk_password), .wk_start(b_wk_start), .wk_from(b_wk_from),
        .wk_to(b_wk_to), .wk_abort(b_wk_abort), .wk_found(b_wk_found),
        .wk_guess(b_wk_guess), .wk_done(b_wk_done), .busy(b_busy), .found(b_found),
        .done(b_done), .cracked_pw(b_cracked_pw), .found_worker(b_found_worker),
        .chunks_issued(b_chunks)
    );

    logic [131:0] a_all;
    logic [131:0] b_all;
    assign a_all = {wk_password, wk_start, wk_from, wk_to, wk_abort, busy, found,
                    done, cracked_pw, found_worker, chunks_issued};
    assign b_all = {b_wk_password, b_wk_start, b_wk_from, b_wk_to, b_wk_abort, b_busy,
                    b_found, b_done, b_cracked_pw, b_found_worker, b_chunks};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input logic [131:0] obs);
        n_cmp++;
        assert (obs === '0) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=0", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One job against the worker-pool model. Workers finish lat_lo..lat_hi
    // cycles after launch. At cycle found_at the running workers in fmask
    // report a match. poke adds stray pulses from idle workers (cycle 1) and
    // a start request mid-job (cycle 3). rst_at > 0 resets mid-job.
    task automatic run_job(input int lat_lo, input int lat_hi, input int found_at,
                           input logic [3:0] fmask, input bit poke, input int rst_at,
                           input logic [31:0] guess2);
        int          total;
        int          issued;
        int          due [NW];
        int          dcyc[NW];
        logic [3:0]  run_v;
        logic [3:0]  fm;
        logic [3:0]  exp4;
        logic [3:0]  exp_abort;
        logic [31:0] g   [NW];
        logic [31:0] pwv;
        int          found_cyc;
        int          exp_fw;
        int          last_done;
        int          elig;
        int          to_e;
        bit          finished;

        total     = (CS + CK - 1) / CK;
        issued    = 0;
        run_v     = '0;
        found_cyc = -1;
        exp_fw    = 0;
        exp_abort = '0;
        last_done = -1;
        finished  = 1'b0;
        for (int i = 0; i < NW; i++) begin
            due[i]  = 0;
            dcyc[i] = -100;
            g[i]    = $urandom;
        end
        g[2]     = guess2;
        wk_guess = {g[3], g[2], g[1], g[0]};
        pwv      = $urandom;

        password_to_crack = pwv;
        wk_done  = '0;
        wk_found = '0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("pw_latched", 64'(wk_password), 64'(pwv));
        chk("status_cleared", 64'({found, done, chunks_issued, cracked_pw}), 64'(0));

        for (int t = 1; t < 400 && !finished; t++) begin
            // Lowest worker idle since at least two cycles ago gets the next range.
            elig = -1;
            for (int i = NW - 1; i >= 0; i--) begin
                if (!run_v[i] && dcyc[i] <= t - 2) elig = i;
            end
            if (t >= 2 && issued < total && elig >= 0 && (found_cyc < 0 || t <= found_cyc)) begin
                exp4 = 4'(1 << elig);
                to_e = issued * CK + CK - 1;
                if (to_e > CS - 1) to_e = CS - 1;
                chk("wk_start", 64'(wk_start), 64'(exp4));
                chk("wk_from", 64'(wk_from[elig*IW +: IW]), 64'(issued * CK));
                chk("wk_to", 64'(wk_to[elig*IW +: IW]), 64'(to_e));
                issued++;
                run_v[elig] = 1'b1;
                due[elig]   = t + int'($urandom_range(lat_hi, lat_lo));
            end else begin
                chk("wk_start_quiet", 64'(wk_start), 64'(0));
            end
            chk("chunks_issued", 64'(chunks_issued), 64'(issued));

            if (found_cyc >= 0 && t == found_cyc + 1)
                chk("wk_abort", 64'(wk_abort), 64'(exp_abort));
            else
                chk("wk_abort_quiet", 64'(wk_abort), 64'(0));

            if (found_cyc >= 0 && t == found_cyc + 2) begin
                chk("found_flags", 64'({busy, found, done}), 64'(3'b011));
                chk("cracked_pw", 64'(cracked_pw), 64'(g[exp_fw]));
                chk("found_worker", 64'(found_worker), 64'(exp_fw));
                finished = 1'b1;
            end else if (found_cyc < 0 && issued == total && run_v == '0 &&
                         last_done >= 0 && t == last_done + 2) begin
                chk("exhaust_flags", 64'({busy, found, done}), 64'(3'b001));
                chk("exhaust_chunks", 64'(chunks_issued), 64'(total));
                finished = 1'b1;
            end else begin
                chk("running_flags", 64'({busy, found, done}), 64'(3'b100));
            end

            if (!finished && t == rst_at) begin
                rst      = 1'b1;
                wk_done  = '0;
                wk_found = '0;
                tick();
                rst = 1'b0;
                chk_zero("reset_mid_job", a_all);
                finished = 1'b1;
            end

            if (!finished) begin
                wk_done  = '0;
                wk_found = '0;
                start    = poke && t == 3;
                if (poke && t == 1) begin
                    wk_done  = '1;
                    wk_found = '1;
                end
                for (int i = 0; i < NW; i++) begin
                    if (run_v[i] && due[i] == t && found_cyc < 0) wk_done[i] = 1'b1;
                end
                if (found_cyc < 0 && t == found_at) begin
                    fm = fmask & run_v;
                    if (fm != '0) begin
                        found_cyc = t;
                        wk_found  = fm;
                        for (int i = NW - 1; i >= 0; i--) if (fm[i]) exp_fw = i;
                        exp_abort = run_v & ~fm & ~wk_done;
                    end
                end
                for (int i = 0; i < NW; i++) begin
                    if (run_v[i] && (wk_done[i] || wk_found[i])) begin
                        run_v[i] = 1'b0;
                        dcyc[i]  = t;
                        if (wk_done[i]) last_done = t;
                    end
                end
                tick();
            end
        end
        start    = 1'b0;
        wk_done  = '0;
        wk_found = '0;
        chk("job_completed", 64'(finished), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bq_from[$];
        int bq_to  [$];
        int bdue   [NW];
        logic [3:0] brun;
        int to_e;

        rst = 1'b1;
        start = 1'b0;
        password_to_crack = '0;
        wk_found = '0;
        wk_done = '0;
        wk_guess = '0;
        b_start = 1'b0;
        b_pw = '0;
        b_wk_found = '0;
        b_wk_done = '0;
        b_wk_guess = '0;
        repeat (3) tick();
        chk_zero("reset_a", a_all);
        chk_zero("reset_b", b_all);
        rst = 1'b0;
        tick();

        // Full search, no match, fixed 10-cycle workers.
        run_job(10, 10, -1, 4'b0000, 1'b0, 0, 32'h0);
        repeat (3) tick();
        chk("sticky_done", 64'({busy, found, done}), 64'(3'b001));

        // Worker 2 matches while 0, 1, 3 are still running.
        run_job(30, 30, 8, 4'b0100, 1'b0, 0, 32'h61626364);
        // Workers 1 and 3 match together: lowest index wins.
        run_job(30, 30, 8, 4'b1010, 1'b0, 0, $urandom);
        // Stray idle-worker pulses and a mid-job start are ignored.
        run_job(3, 8, -1, 4'b0000, 1'b1, 0, $urandom);
        // Reset mid-job, then a new job starts again from index 0.
        run_job(10, 10, -1, 4'b0000, 1'b0, 6, $urandom);
        tick();
        run_job(2, 6, -1, 4'b0000, 1'b0, 0, $urandom);

        // Randomized jobs.
        for (int j = 0; j < 12; j++) begin
            run_job(1, 12, ($urandom_range(1, 0) == 1) ? int'($urandom_range(40, 3)) : -1,
                    4'($urandom), 1'($urandom), 0, $urandom);
            tick();
        end

        // Short charset: last chunk clamped to 8-9.
        brun = '0;
        for (int i = 0; i < NW; i++) bdue[i] = 0;
        b_pw = 32'h12345678;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int t = 1; t < 100 && !b_done; t++) begin
            for (int i = 0; i < NW; i++) begin
                if (b_wk_start[i]) begin
                    bq_from.push_back(int'(b_wk_from[i*IW +: IW]));
                    bq_to.push_back(int'(b_wk_to[i*IW +: IW]));
                    brun[i] = 1'b1;
                    bdue[i] = t + 3;
                end
            end
            b_wk_done = '0;
            for (int i = 0; i < NW; i++) begin
                if (brun[i] && bdue[i] == t) begin
                    b_wk_done[i] = 1'b1;
                    brun[i] = 1'b0;
                end
            end
            tick();
        end
        b_wk_done = '0;
        chk("b_done", 64'({b_busy, b_found, b_done}), 64'(3'b001));
        chk("b_ranges", 64'(bq_from.size()), 64'(3));
        for (int k = 0; k < bq_from.size() && k < 3; k++) begin
            to_e = k * 4 + 3;
            if (to_e > 9) to_e = 9;
            chk("b_from", 64'(bq_from[k]), 64'(k * 4));
            chk("b_to", 64'(bq_to[k]), 64'(to_e));
        end
        chk("b_chunks", 64'(b_chunks), 64'(3));
        chk("b_no_match", 64'({b_cracked_pw, b_found_worker, b_wk_abort}), 64'(0));
        chk("b_pw", 64'(b_wk_password), 64'(32'h12345678));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
